// File: rtl/arb_rr_byte_packer_pkg.sv
// arb_rr_byte_packer_pkg: shared state encoding and word/slot geometry for the round-robin byte packer arbiter.
package arb_rr_byte_packer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      PAD  = 2'd2
   } state_t;

   localparam int SLOT_W         = 2;
   localparam int SLOTS_PER_WORD = 4;
   localparam int SRC_W          = 3;

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_WORD - 1);

   // Distance walked from the pointer to reach index j, counting the slot right after the pointer as 0.
   function automatic int rr_dist(input int j, input int ptr, input int n);
      return (j - ptr - 1 + 2 * n) % n;
   endfunction

endpackage

// File: rtl/arb_rr_byte_packer_rr_pick.sv
// arb_rr_byte_packer_rr_pick: combinational round-robin selector; first requester strictly after the pointer wins.
module arb_rr_byte_packer_rr_pick
   import arb_rr_byte_packer_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [SRC_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [SRC_W-1:0] o_idx,
   output logic             o_any
);

   int w_best;

   always_comb begin
      o_idx  = '0;
      o_any  = 1'b0;
      w_best = N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
         if (i_req[j] && rr_dist(j, int'(i_ptr), N_REQ) < w_best) begin
            w_best = rr_dist(j, int'(i_ptr), N_REQ);
            o_idx  = SRC_W'(j);
            o_any  = 1'b1;
         end
      end
      o_gnt = o_any ? (N_REQ'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/arb_rr_byte_packer.sv
// arb_rr_byte_packer: word-granular round-robin arbiter feeding one 8b->32b packer with tagged bytes.
// Optional partial-word padding after a stall is enabled by defining ARB_PAD_EN.
module arb_rr_byte_packer
   import arb_rr_byte_packer_pkg::*;
#(
   parameter int          N_REQ    = 2,
   parameter int          PAD_WAIT = 4,
   parameter logic [7:0]  PAD_BYTE = 8'h00
) (
   input  logic                 clk_4f,
   input  logic                 reset_L,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 pk_valid_out,
   output logic [7:0]           pk_data_out,
   output logic [SLOT_W-1:0]    pk_slot,
   output logic [SRC_W-1:0]     pk_src_id,
   output logic                 pk_eow,
   output logic                 pk_padded
);

   state_t             r_state, w_next;
   logic [SLOT_W-1:0]  r_slot;
   logic [N_REQ-1:0]   r_gnt, w_gnt;
   logic [SRC_W-1:0]   r_src, r_ptr, w_idx, w_ptr;
   logic               w_any, w_acc, w_pad_step, w_done, w_arb, w_emit;
   logic [7:0]         w_byte;

   // While a word is open the grant itself is the pointer, so completion re-arbitrates past the owner.
   assign w_ptr = (r_state == IDLE) ? r_ptr : r_src;

   arb_rr_byte_packer_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .i_req (req_valid),
      .i_ptr (w_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_comb begin
      w_byte = '0;
      for (int j = 0; j < N_REQ; j++)
         if (r_src == SRC_W'(j)) w_byte = req_data[8*j +: 8];
   end

`ifdef ARB_PAD_EN
   localparam int STALL_W = $clog2(PAD_WAIT + 1);
   logic [STALL_W-1:0] r_stall;
   logic               w_gv, w_stall, w_to_pad;

   assign w_gv     = |(req_valid & r_gnt);
   assign w_stall  = (r_state == BUSY) && (r_slot != '0) && !w_gv;
   assign w_to_pad = w_stall && (r_stall == STALL_W'(PAD_WAIT - 1));

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) r_stall <= '0;
      else          r_stall <= (w_stall && !w_to_pad) ? r_stall + 1'b1 : '0;
   end
`else
   logic w_unused;
   assign w_unused = (PAD_WAIT > 0);
`endif

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (r_state == IDLE || w_done) w_next = w_any ? BUSY : IDLE;
`ifdef ARB_PAD_EN
      else if (w_to_pad) w_next = PAD;
`endif
   end

   always_comb begin
      req_ready  = (r_state == BUSY) ? r_gnt : '0;
      w_acc      = |(req_valid & req_ready);
`ifdef ARB_PAD_EN
      w_pad_step = (r_state == PAD);
`else
      w_pad_step = 1'b0;
`endif
      w_emit     = w_acc | w_pad_step;
      w_done     = w_emit && (r_slot == LAST_SLOT);
      w_arb      = (r_state == IDLE) || w_done;
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         r_slot       <= '0;
         r_gnt        <= '0;
         r_src        <= '0;
         r_ptr        <= SRC_W'(N_REQ - 1);
         pk_valid_out <= 1'b0;
         pk_data_out  <= '0;
         pk_slot      <= '0;
         pk_src_id    <= '0;
         pk_eow       <= 1'b0;
         pk_padded    <= 1'b0;
      end else begin
         if (w_arb) begin
            r_gnt <= w_gnt;
            r_src <= w_idx;
         end
         if (w_done) r_ptr <= r_src;
         if (w_emit) begin
            r_slot      <= r_slot + 1'b1;
            pk_data_out <= w_pad_step ? PAD_BYTE : w_byte;
            pk_slot     <= r_slot;
            pk_src_id   <= r_src;
         end
         pk_valid_out <= w_emit;
         pk_eow       <= w_done;
         pk_padded    <= w_pad_step;
      end
   end

endmodule

// File: tb/tb_arb_rr_byte_packer.sv
// tb_arb_rr_byte_packer: directed checks of grant order, slot tagging, stalls, padding and reset on N_REQ=2 and N_REQ=4 builds.
module tb_arb_rr_byte_packer;

   logic        clk_4f = 1'b0;
   logic        reset_L = 1'b0;

   logic [1:0]  v2, r2;
   logic [15:0] d2;
   logic        pv2, pe2, pp2;
   logic [7:0]  pd2;
   logic [1:0]  ps2;
   logic [2:0]  pi2;

   logic [3:0]  v4, r4;
   logic [31:0] d4;
   logic        pv4, pe4, pp4;
   logic [7:0]  pd4;
   logic [1:0]  ps4;
   logic [2:0]  pi4;

   logic [15:0] o2, o4;
   logic [15:0] exp;
   logic [1:0]  er;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] bytes_single [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

   assign o2 = {pv2, pd2, ps2, pi2, pe2, pp2};
   assign o4 = {pv4, pd4, ps4, pi4, pe4, pp4};

   always #5 clk_4f = ~clk_4f;

   arb_rr_byte_packer #(.N_REQ(2), .PAD_WAIT(4), .PAD_BYTE(8'h00)) u_dut2 (
      .clk_4f       (clk_4f),
      .reset_L      (reset_L),
      .req_valid    (v2),
      .req_data     (d2),
      .req_ready    (r2),
      .pk_valid_out (pv2),
      .pk_data_out  (pd2),
      .pk_slot      (ps2),
      .pk_src_id    (pi2),
      .pk_eow       (pe2),
      .pk_padded    (pp2)
   );

   arb_rr_byte_packer #(.N_REQ(4)) u_dut4 (
      .clk_4f       (clk_4f),
      .reset_L      (reset_L),
      .req_valid    (v4),
      .req_data     (d4),
      .req_ready    (r4),
      .pk_valid_out (pv4),
      .pk_data_out  (pd4),
      .pk_slot      (ps4),
      .pk_src_id    (pi4),
      .pk_eow       (pe4),
      .pk_padded    (pp4)
   );

   task automatic do_reset();
      @(negedge clk_4f);
      reset_L = 1'b0;
      v2 = '0; d2 = '0; v4 = '0; d4 = '0;
      repeat (2) @(negedge clk_4f);
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      v2 = '0; d2 = '0; v4 = '0; d4 = '0;
      reset_L = 1'b0;
      #1;
      n_tests++;
      if ({r2, o2, r4, o4} !== 38'h0) begin
         n_fail++;
         $display("FAIL reset_assert got=%h exp=0", {r2, o2, r4, o4});
      end
      do_reset();
      @(negedge clk_4f);
      n_tests++;
      if ({r2, o2, r4, o4} !== 38'h0) begin
         n_fail++;
         $display("FAIL reset_idle got=%h exp=0", {r2, o2, r4, o4});
      end
   endtask

   task automatic test_single();
      do_reset();
      v2 = 2'b01;
      d2[7:0] = bytes_single[0];
      @(negedge clk_4f);
      n_tests++;
      if ({r2, o2} !== {2'b01, 16'h0}) begin
         n_fail++;
         $display("FAIL single_grant got=%h exp=%h", {r2, o2}, {2'b01, 16'h0});
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_4f);
         exp = {1'b1, bytes_single[i], 2'(i), 3'd0, (i == 3), 1'b0};
         n_tests++;
         if (o2 !== exp) begin
            n_fail++;
            $display("FAIL single_byte i=%0d got=%h exp=%h", i, o2, exp);
         end
         if (i < 3) d2[7:0] = bytes_single[i+1];
      end
      v2 = '0;
   endtask

   task automatic test_contention();
      do_reset();
      v2 = 2'b11;
      d2 = {8'hB1, 8'hA0};
      @(negedge clk_4f);
      n_tests++;
      if ({r2, pv2} !== 3'b010) begin
         n_fail++;
         $display("FAIL cont_grant got=%b exp=010", {r2, pv2});
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk_4f);
         exp = {1'b1, ((k / 4) % 2 == 1) ? 8'hB1 : 8'hA0, 2'(k % 4), 3'((k / 4) % 2), (k % 4 == 3), 1'b0};
         er  = ((k / 4) % 2 == 1) ^ (k % 4 == 3) ? 2'b10 : 2'b01;
         n_tests++;
         if ({r2, o2} !== {er, exp}) begin
            n_fail++;
            $display("FAIL cont_word k=%0d got=%h exp=%h", k, {r2, o2}, {er, exp});
         end
      end
      v2 = '0;
   endtask

`ifndef ARB_PAD_EN
   task automatic test_stall();
      do_reset();
      v2 = 2'b11;
      d2 = {8'h5A, 8'h11};
      @(negedge clk_4f);
      @(negedge clk_4f);
      d2[7:0] = 8'h22;
      @(negedge clk_4f);
      n_tests++;
      if (o2 !== {1'b1, 8'h22, 2'd1, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL stall_pre got=%h exp=%h", o2, {1'b1, 8'h22, 2'd1, 3'd0, 1'b0, 1'b0});
      end
      v2 = 2'b10;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_4f);
         n_tests++;
         if ({r2, pv2} !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_hold k=%0d got=%b exp=010", k, {r2, pv2});
         end
      end
      v2 = 2'b11;
      d2[7:0] = 8'h33;
      @(negedge clk_4f);
      n_tests++;
      if (o2 !== {1'b1, 8'h33, 2'd2, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL stall_resume got=%h exp=%h", o2, {1'b1, 8'h33, 2'd2, 3'd0, 1'b0, 1'b0});
      end
      d2[7:0] = 8'h44;
      @(negedge clk_4f);
      n_tests++;
      if ({r2, o2} !== {2'b10, 1'b1, 8'h44, 2'd3, 3'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL stall_eow got=%h exp=%h", {r2, o2}, {2'b10, 1'b1, 8'h44, 2'd3, 3'd0, 1'b1, 1'b0});
      end
      v2 = 2'b10;
      @(negedge clk_4f);
      n_tests++;
      if (o2 !== {1'b1, 8'h5A, 2'd0, 3'd1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL stall_next got=%h exp=%h", o2, {1'b1, 8'h5A, 2'd0, 3'd1, 1'b0, 1'b0});
      end
      v2 = '0;
   endtask
`else
   task automatic test_pad();
      do_reset();
      v2 = 2'b01;
      d2[7:0] = 8'h11;
      @(negedge clk_4f);
      @(negedge clk_4f);
      v2 = 2'b00;
      // three idle cycles must not trigger padding
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_4f);
         n_tests++;
         if ({r2, pv2} !== 3'b010) begin
            n_fail++;
            $display("FAIL pad_short k=%0d got=%b exp=010", k, {r2, pv2});
         end
      end
      v2 = 2'b01;
      d2[7:0] = 8'h22;
      @(negedge clk_4f);
      n_tests++;
      if (o2 !== {1'b1, 8'h22, 2'd1, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL pad_resume got=%h exp=%h", o2, {1'b1, 8'h22, 2'd1, 3'd0, 1'b0, 1'b0});
      end
      v2 = 2'b00;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_4f);
         er = (k == 3) ? 2'b00 : 2'b01;
         n_tests++;
         if ({r2, pv2} !== {er, 1'b0}) begin
            n_fail++;
            $display("FAIL pad_wait k=%0d got=%b exp=%b", k, {r2, pv2}, {er, 1'b0});
         end
      end
      @(negedge clk_4f);
      n_tests++;
      if ({r2, o2} !== {2'b00, 1'b1, 8'h00, 2'd2, 3'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL pad_slot2 got=%h exp=%h", {r2, o2}, {2'b00, 1'b1, 8'h00, 2'd2, 3'd0, 1'b0, 1'b1});
      end
      @(negedge clk_4f);
      n_tests++;
      if (o2 !== {1'b1, 8'h00, 2'd3, 3'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL pad_slot3 got=%h exp=%h", o2, {1'b1, 8'h00, 2'd3, 3'd0, 1'b1, 1'b1});
      end
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      v2 = 2'b11;
      d2 = {8'hC1, 8'hC0};
      repeat (3) @(negedge clk_4f);
      n_tests++;
      if (o2 !== {1'b1, 8'hC0, 2'd1, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rmid_pre got=%h exp=%h", o2, {1'b1, 8'hC0, 2'd1, 3'd0, 1'b0, 1'b0});
      end
      #2 reset_L = 1'b0;
      #1;
      n_tests++;
      if ({r2, o2} !== 18'h0) begin
         n_fail++;
         $display("FAIL rmid_async got=%h exp=0", {r2, o2});
      end
      @(negedge clk_4f);
      reset_L = 1'b1;
      @(negedge clk_4f);
      n_tests++;
      if ({r2, o2} !== {2'b01, 16'h0}) begin
         n_fail++;
         $display("FAIL rmid_grant got=%h exp=%h", {r2, o2}, {2'b01, 16'h0});
      end
      @(negedge clk_4f);
      n_tests++;
      if (o2 !== {1'b1, 8'hC0, 2'd0, 3'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rmid_restart got=%h exp=%h", o2, {1'b1, 8'hC0, 2'd0, 3'd0, 1'b0, 1'b0});
      end
      v2 = '0;
   endtask

   task automatic test_rotation();
      do_reset();
      v4 = 4'b1000;
      d4 = {8'hD3, 8'h00, 8'h71, 8'h00};
      @(negedge clk_4f);
      n_tests++;
      if (r4 !== 4'b1000) begin
         n_fail++;
         $display("FAIL rot_first got=%b exp=1000", r4);
      end
      repeat (3) @(negedge clk_4f);
      v4 = 4'b1010;
      @(negedge clk_4f);
      n_tests++;
      if ({r4, o4} !== {4'b0010, 1'b1, 8'hD3, 2'd3, 3'd3, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rot_to1 got=%h exp=%h", {r4, o4}, {4'b0010, 1'b1, 8'hD3, 2'd3, 3'd3, 1'b1, 1'b0});
      end
      repeat (4) @(negedge clk_4f);
      n_tests++;
      if ({r4, o4} !== {4'b1000, 1'b1, 8'h71, 2'd3, 3'd1, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL rot_to3 got=%h exp=%h", {r4, o4}, {4'b1000, 1'b1, 8'h71, 2'd3, 3'd1, 1'b1, 1'b0});
      end
      @(negedge clk_4f);
      n_tests++;
      if (o4 !== {1'b1, 8'hD3, 2'd0, 3'd3, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rot_src3 got=%h exp=%h", o4, {1'b1, 8'hD3, 2'd0, 3'd3, 1'b0, 1'b0});
      end
      v4 = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
`ifndef ARB_PAD_EN
      test_stall();
`else
      test_pad();
`endif
      test_reset_mid();
      test_rotation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
